// File: rtl/config_ring_counter_pkg.sv
// Shared definitions for the configurable ring / Johnson counter.
//   MODE_* : encodings of the 'mode' input
//   DIR_*  : encodings of the 'dir' input
//   home_pattern(width) : the HOME pattern (only the MSB set), returned
//                         LSB-aligned in a 32-bit word; callers cast it
//                         down to their own width.
package config_ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_TO_LSB   = 1'b0;
  localparam logic DIR_TO_MSB   = 1'b1;

  function automatic logic [31:0] home_pattern(input int unsigned width);
    home_pattern = 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/config_ring_counter_ring_state_check.sv
// Combinational legality check for the counter state.
//   q     : current counter state
//   mode  : MODE_RING or MODE_JOHNSON
//   legal : 1 when q is one of the states reachable in the given mode
// Ring    : exactly one bit set.
// Johnson : at most one boundary between adjacent bits, which covers
//           ones-then-zeros, zeros-then-ones, all-zeros and all-ones
//           (2*WIDTH states).
module ring_state_check
  import config_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  logic             one_hot;
  logic             twisted;
  logic [WIDTH-2:0] trans;

  // A 1 in trans marks a boundary between bit i+1 and bit i.
  assign trans   = q[WIDTH-1:1] ^ q[WIDTH-2:0];

  // x & (x-1) clears the lowest set bit: zero means at most one bit set.
  assign one_hot = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
  assign twisted = (trans & (trans - (WIDTH-1)'(1))) == '0;

  assign legal   = (mode == MODE_JOHNSON) ? twisted : one_hot;

endmodule

// File: rtl/config_ring_counter.sv
// Configurable ring / Johnson counter with parallel load and
// illegal-state correction.
//   c        : clock, rising edge
//   rst      : synchronous active-low reset, forces HOME
//   en       : step enable
//   mode     : 0 ring (one-hot), 1 Johnson (twisted ring)
//   dir      : 0 shift toward LSB, 1 shift toward MSB
//   load     : parallel load strobe, wins over en
//   load_val : value captured on load (not checked)
//   q        : registered counter state
//   wrap     : one-cycle pulse after a legal step that lands on HOME
//   err      : one-cycle pulse after an illegal state is forced to HOME
module config_ring_counter
  import config_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME = WIDTH'(home_pattern(WIDTH));

  logic             legal;
  logic             fb;
  logic [WIDTH-1:0] step_q;

  // Legality is looked at only when en is high, so an illegal loaded
  // value can sit untouched while the counter is idle.
  ring_state_check #(.WIDTH(WIDTH)) u_check (
    .q     (q),
    .mode  (mode),
    .legal (legal)
  );

  // Next state for one step. The bit shifted in is the bit falling off
  // the other end, inverted in Johnson mode.
  always_comb begin
    fb     = 1'b0;
    step_q = q;
    if (dir == DIR_TO_MSB) begin
      fb     = q[WIDTH-1] ^ (mode == MODE_JOHNSON);
      step_q = {q[WIDTH-2:0], fb};
    end else begin
      fb     = q[0] ^ (mode == MODE_JOHNSON);
      step_q = {fb, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge c) begin
    if (!rst) begin
      q    <= HOME;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (en) begin
      if (legal) begin
        q    <= step_q;
        wrap <= (step_q == HOME);
        err  <= 1'b0;
      end else begin
        q    <= HOME;
        wrap <= 1'b0;
        err  <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_ring_counter.sv
// Directed bench for config_ring_counter at WIDTH=4. Each task drives one
// scenario and compares {q, wrap, err} against hand-computed values one
// time unit after the rising edge.
module tb_config_ring_counter;

  logic       c = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'b0000;
  logic [3:0] q;
  logic       wrap;
  logic       err;

  int tests = 0;
  int fails = 0;

  config_ring_counter #(.WIDTH(4)) dut (
    .c        (c),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    // first edge with rst low
    rst = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'b0101;
    tick();
    tests++;
    if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_init: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=0", q, wrap, err);
    end
    // load 0101, then assert rst and confirm no effect before the edge
    rst = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'b0101;
    tick();
    load = 1'b0;
    rst = 1'b0;
    #2;
    tests++;
    if (q !== 4'b0101) begin
      fails++;
      $display("FAIL reset_not_async: got q=%b want q=0101", q);
    end
    tick();
    tests++;
    if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_sync: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=0", q, wrap, err);
    end
    rst = 1'b1;
  endtask

  task automatic test_ring_to_lsb();
    logic [3:0] exp_q [4];
    logic       exp_w [4];
    exp_q = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({q, wrap, err} !== {exp_q[i], exp_w[i], 1'b0}) begin
        fails++;
        $display("FAIL ring_lsb step %0d: got q=%b wrap=%b err=%b want q=%b wrap=%b err=0",
                 i, q, wrap, err, exp_q[i], exp_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_johnson_to_lsb();
    logic [3:0] exp_q [8];
    exp_q = '{4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    do_reset();
    mode = 1'b1; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if ({q, wrap, err} !== {exp_q[i], (i == 7), 1'b0}) begin
        fails++;
        $display("FAIL johnson_lsb step %0d: got q=%b wrap=%b err=%b want q=%b wrap=%b err=0",
                 i, q, wrap, err, exp_q[i], (i == 7));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_johnson_msb_then_ring();
    logic [3:0] exp_j [8];
    logic [3:0] exp_r [4];
    exp_j = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    mode = 1'b1; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if ({q, wrap, err} !== {exp_j[i], (i == 7), 1'b0}) begin
        fails++;
        $display("FAIL johnson_msb step %0d: got q=%b wrap=%b err=%b want q=%b wrap=%b err=0",
                 i, q, wrap, err, exp_j[i], (i == 7));
      end
    end
    // switch to ring with no hold cycle
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({q, wrap, err} !== {exp_r[i], (i == 3), 1'b0}) begin
        fails++;
        $display("FAIL ring_msb step %0d: got q=%b wrap=%b err=%b want q=%b wrap=%b err=0",
                 i, q, wrap, err, exp_r[i], (i == 3));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_illegal();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      mode = m[0]; dir = 1'b0;
      load = 1'b1; load_val = 4'b0110; en = 1'b0;
      tick();
      load = 1'b0;
      tests++;
      if ({q, wrap, err} !== {4'b0110, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL load mode%0d: got q=%b wrap=%b err=%b want q=0110 wrap=0 err=0", m, q, wrap, err);
      end
      // illegal value sits quietly while idle
      repeat (3) tick();
      tests++;
      if ({q, wrap, err} !== {4'b0110, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL illegal_idle mode%0d: got q=%b wrap=%b err=%b want q=0110 wrap=0 err=0", m, q, wrap, err);
      end
      en = 1'b1;
      tick();
      en = 1'b0;
      tests++;
      if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL correct mode%0d: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=1", m, q, wrap, err);
      end
      tick();
      tests++;
      if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL err_pulse mode%0d: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=0", m, q, wrap, err);
      end
    end
    // legal Johnson load steps normally: 0011 toward LSB -> 0001
    mode = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'b0011;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    tests++;
    if ({q, wrap, err} !== {4'b0001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL johnson_load_step: got q=%b wrap=%b err=%b want q=0001 wrap=0 err=0", q, wrap, err);
    end
  endtask

  task automatic test_priority();
    do_reset();
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    tick(); tick();
    tests++;
    if (q !== 4'b0010) begin
      fails++;
      $display("FAIL prio_setup: got q=%b want q=0010", q);
    end
    // load beats en
    load = 1'b1; load_val = 4'b0101;
    tick();
    tests++;
    if ({q, wrap, err} !== {4'b0101, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL load_over_en: got q=%b wrap=%b err=%b want q=0101 wrap=0 err=0", q, wrap, err);
    end
    // back to 0010, then rst beats load
    en = 1'b0; load_val = 4'b0010;
    tick();
    rst = 1'b0; load = 1'b1; load_val = 4'b0110; en = 1'b1;
    tick();
    tests++;
    if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_over_load: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=0", q, wrap, err);
    end
    rst = 1'b1; load = 1'b0;
    // resumes from HOME on the first enabled cycle
    tick();
    en = 1'b0;
    tests++;
    if ({q, wrap, err} !== {4'b0100, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL resume_home: got q=%b wrap=%b err=%b want q=0100 wrap=0 err=0", q, wrap, err);
    end
  endtask

  task automatic test_hold();
    do_reset();
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) mode = 1'b1;
      tick();
      tests++;
      if ({q, wrap, err} !== {4'b0100, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL hold cycle %0d: got q=%b wrap=%b err=%b want q=0100 wrap=0 err=0", i, q, wrap, err);
      end
    end
    // 0100 is not a Johnson state: corrected on the next enabled step
    en = 1'b1;
    tick();
    tests++;
    if ({q, wrap, err} !== {4'b1000, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mode_switch_correct: got q=%b wrap=%b err=%b want q=1000 wrap=0 err=1", q, wrap, err);
    end
    tick();
    en = 1'b0;
    tests++;
    if ({q, wrap, err} !== {4'b1100, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL after_correct: got q=%b wrap=%b err=%b want q=1100 wrap=0 err=0", q, wrap, err);
    end
  endtask

  initial begin
    test_reset();
    test_ring_to_lsb();
    test_johnson_to_lsb();
    test_johnson_msb_then_ring();
    test_load_illegal();
    test_priority();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/config_ring_counter.md
CONFIG_RING_COUNTER -- requirements
Module: config_ring_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter width; legal range is 2..32.
REQ-002 The block SHALL have port c, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: step enable.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = shift toward LSB, 1 = shift toward MSB.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: value captured on load.
REQ-009 The block SHALL have port q, output, WIDTH bits: counter state, registered.
REQ-010 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on return to the HOME pattern.
REQ-011 The block SHALL have port err, output, 1 bit: registered one-cycle pulse on an illegal-state correction.

Function
REQ-012 HOME SHALL be the pattern with only q[WIDTH-1] set (for WIDTH=4, 1000); it is legal in both modes.
REQ-013 Update priority SHALL be, per rising edge of c: rst low, then load, then en, then hold.
REQ-014 When load=1, q SHALL take load_val unchecked, with wrap=0 and err=0.
REQ-015 When en=1 and q is legal for the current mode, q SHALL take one step per REQ-016..019.
REQ-016 Ring, dir=0 SHALL step as: q[i] <= q[i+1], q[WIDTH-1] <= q[0].
REQ-017 Ring, dir=1 SHALL step as: q[i] <= q[i-1], q[0] <= q[WIDTH-1].
REQ-018 Johnson, dir=0 SHALL step as: q[i] <= q[i+1], q[WIDTH-1] <= ~q[0].
REQ-019 Johnson, dir=1 SHALL step as: q[i] <= q[i-1], q[0] <= ~q[WIDTH-1].
REQ-020 Ring legality SHALL be: exactly one bit of q set.
REQ-021 Johnson legality SHALL be: q of the form ones-then-zeros from the MSB, or zeros-then-ones toward the LSB. All-zeros and all-ones are legal; there are 2*WIDTH legal states.
REQ-022 When en=1 and q is illegal for the current mode, q SHALL become HOME and err SHALL be 1 for exactly that cycle, with wrap=0.
REQ-023 wrap SHALL be 1 for the one cycle after a legal step whose result equals HOME, and 0 otherwise.
REQ-024 Ring period SHALL be WIDTH steps and Johnson period SHALL be 2*WIDTH steps, from HOME back to HOME.
REQ-025 Changes to mode or dir SHALL take effect on the next enabled step without a hold cycle; a state illegal under the new mode is corrected per REQ-022.
REQ-026 With en=0 and load=0, q SHALL hold and wrap=err=0.
REQ-027 Legality SHALL be evaluated only on enabled steps; an illegal q may sit indefinitely while en=0.

Reset
REQ-028 On a rising edge of c with rst=0, q SHALL become HOME and wrap=err=0, regardless of en, load, mode or dir.
REQ-029 Reset mid-sequence SHALL discard the current state; the counter resumes from HOME on the first enabled cycle after rst=1.
REQ-030 Reset SHALL have no asynchronous effect; the outputs are unchanged until the clock edge.

Structure
REQ-031 A shared package SHALL hold the constants MODE_RING=0, MODE_JOHNSON=1, DIR_TO_LSB=0, DIR_TO_MSB=1, and the HOME pattern as a width-parametrised function.
REQ-032 One combinational sub-module SHALL exist, ring_state_check, with parameter WIDTH, inputs q and mode, and output legal, implementing REQ-020 and REQ-021.
REQ-033 All state SHALL be in a single clocked process using non-blocking assignments only.

Verification (WIDTH=4)
REQ-034 Scenario: reset, mode=0, dir=0, en=1 for 4 cycles -> q = 0100, 0010, 0001, 1000, with wrap=1 only on the 4th.
REQ-035 Scenario: reset, mode=1, dir=0, en=1 for 8 cycles -> q = 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000, with wrap only on the 8th.
REQ-036 Scenario: reset, mode=1, dir=1, en=1 -> q = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000; then mode=0, dir=1 -> q = 0001, 0010, 0100, 1000.
REQ-037 Scenario: load=1 with load_val=0110 in mode=0, then en=1 -> q=0110 after load; next cycle q=1000, err=1 for one cycle, wrap=0. In mode=1, the same 0110 is also corrected.
REQ-038 Scenario: load and en both high, and separately rst low with load high, at q=0010 -> the load wins over en; rst wins over load, giving q=1000, wrap=0, err=0.
REQ-039 Scenario: en=0 for 10 cycles mid-sequence -> q constant and no pulses; a mode toggle with en=0 produces no change until the next enabled step.
